// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and constants for the usart transmit arbiter
//   state_t       : arbiter FSM encoding (IDLE, SEND, DRAIN)
//   FRAME_TICKS   : usart frame length in baud ticks (start, 8 data, 2 stop)
//   DEFAULT_NUM_REQ, oh_to_idx() : default requester count, one-hot to index helper
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FRAME_TICKS     = 11;
    localparam int DEFAULT_NUM_REQ = 4;

    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        oh_to_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) oh_to_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake, usart side and status signals of the arbiter
//   requester side : req_valid, req_data, req_lock -> req_ready, tx_done
//   usart side     : bytetosend, send -> usart ; sent <- usart
//   status         : busy, owner
//   slave modport for the arbiter, master modport for whoever drives requests and sent
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   tx_done;
    logic [7:0]           bytetosend;
    logic                 send;
    logic                 sent;
    logic                 busy;
    logic [2:0]           owner;

    modport slave (
        input  req_valid, req_data, req_lock, sent,
        output req_ready, tx_done, bytetosend, send, busy, owner
    );

    modport master (
        output req_valid, req_data, req_lock, sent,
        input  req_ready, tx_done, bytetosend, send, busy, owner
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational rotating-priority one-hot picker
//   valid : request vector
//   last  : index of the previous winner; the search starts at last+1 and wraps
//   grant : one-hot winner, zero when nothing is valid
module uart_tx_arbiter_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] valid,
    input  logic [2:0]   last,
    output logic [N-1:0] grant
);

    logic [3:0]   sh;
    logic [N-1:0] rot;
    logic [N-1:0] low;

    // Rotate so requester last+1 sits at bit 0, keep the lowest set bit, rotate back.
    // The shift never exceeds N, so the doubled vector covers every wrap case.
    assign sh    = {1'b0, last} + 4'd1;
    assign rot   = N'({valid, valid} >> sh);
    assign low   = rot & (~rot + N'(1));
    assign grant = N'(({low, low} << sh) >> N);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, lock-aware sharing of one usart transmitter among NUM_REQ byte producers
//   clock, reset_n : system clock (shared with usart), asynchronous active-low reset
//   bus (slave)    : req_valid/req_data/req_lock in, req_ready/tx_done out,
//                    bytetosend/send to usart, sent from usart, busy/owner status
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);

    state_t             state;
    logic               lock;
    logic [2:0]         owner;
    logic [7:0]         byte_q;
    logic               send_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] ready;
    logic [7:0]         sel_byte;

    uart_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid (bus.req_valid),
        .last  (owner),
        .grant (pick)
    );

    assign owner_oh = NUM_REQ'(1) << owner;

    // Under lock only the owner is eligible; the others wait even while the owner is silent.
    assign ready = (state != IDLE) ? '0 : lock ? (owner_oh & bus.req_valid) : pick;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_byte |= ready[i] ? bus.req_data[8*i +: 8] : 8'h00;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.tx_done    = done_q;
    assign bus.bytetosend = byte_q;
    assign bus.send       = send_q;
    assign bus.busy       = state != IDLE;
    assign bus.owner      = owner;

    // send drops as soon as sent is seen (final stop bit), well before usart
    // returns to idle, so no second frame can start from a stale send.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            lock   <= 1'b0;
            owner  <= 3'(NUM_REQ - 1);
            byte_q <= '0;
            send_q <= 1'b0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (|ready) begin
                        byte_q <= sel_byte;
                        owner  <= oh_to_idx(8'(ready));
                        send_q <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.sent) begin
                        send_q <= 1'b0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.sent) begin
                        done_q <= owner_oh;
                        lock   <= |(bus.req_lock & owner_oh);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench with a behavioural usart and arbitration model
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NR  = 4;
    localparam int DIV = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // behavioural usart: one baud tick every DIV clocks, bits taken live from bytetosend
    int          tdiv   = 0;
    int          ubit   = -1;
    int          frames = 0;
    logic [10:0] fbits  = '0;
    logic [10:0] last_frame = '0;
    logic [7:0]  line_q[$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tdiv     <= 0;
            ubit     <= -1;
            fbits    <= '0;
            bus.sent <= 1'b0;
        end else begin
            tdiv <= (tdiv == DIV - 1) ? 0 : tdiv + 1;
            if (tdiv == DIV - 1) begin
                if (ubit == FRAME_TICKS - 1) begin
                    line_q.push_back(fbits[8:1]);
                    last_frame <= fbits;
                    frames     <= frames + 1;
                end
                if (ubit < 0 || ubit == FRAME_TICKS - 1) begin
                    ubit     <= bus.send ? 0 : -1;
                    fbits    <= '0;
                    bus.sent <= 1'b0;
                end else begin
                    ubit             <= ubit + 1;
                    fbits[ubit + 1]  <= (ubit < 8) ? bus.bytetosend[ubit] : 1'b1;
                    bus.sent         <= (ubit + 1 == FRAME_TICKS - 1);
                end
            end
        end
    end

    // reference model state
    int            m_owner = NR - 1;
    logic          m_lock  = 1'b0;
    logic          m_busy  = 1'b0;
    logic [7:0]    m_byte  = 8'h00;
    logic [7:0]    pq [NR][$];
    logic [NR-1:0] lock_en    = '0;
    logic [NR-1:0] force_lock = '0;
    int            acc_log[$];
    logic [7:0]    line_log[$];
    int            done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner(input logic [NR-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NR; k++) begin
            if (v[(m_owner + k) % NR]) return (m_owner + k) % NR;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pq[i].size();
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]      = pq[i].size() != 0;
            bus.req_data[8*i +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'hFF;
            bus.req_lock[i]       = force_lock[i] | (lock_en[i] & (pq[i].size() != 0));
        end
    endtask

    task automatic push(input int r, input logic [7:0] b);
        pq[r].push_back(b);
    endtask

    task automatic step();
        int   w;
        logic took;
        took = 1'b0;
        w    = -1;
        @(negedge clock);
        if (reset_n) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("owner", 32'(bus.owner), m_owner);
            chk("bytetosend", 32'(bus.bytetosend), 32'(m_byte));
            w = m_busy ? -1 : exp_winner(bus.req_valid);
            chk("req_ready", 32'(bus.req_ready), (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
                took    = 1'b1;
                m_busy  = 1'b1;
                m_owner = w;
                m_byte  = pq[w][0];
                acc_log.push_back(w);
            end
        end
        @(posedge clock);
        #1;
        if (bus.tx_done !== '0) begin
            chk("tx_done", 32'(bus.tx_done), m_busy ? (1 << m_owner) : 0);
            chk("frames_at_done", line_q.size(), 1);
            if (line_q.size() != 0) begin
                chk("line_byte", 32'(line_q[0]), 32'(m_byte));
                line_log.push_back(line_q.pop_front());
            end
            m_lock = bus.req_lock[m_owner];
            m_busy = 1'b0;
            done_cnt++;
        end
        if (took) void'(pq[w].pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((pending() != 0 || m_busy) && n < limit) begin
            step();
            n++;
        end
        chk("drain_timeout", pending() + int'(m_busy), 0);
    endtask

    initial begin
        int         base;
        int         n0;
        int         n;
        int         dsave;
        logic [7:0] exp5 [5];
        exp5 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h5A};
        drive();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_send", 32'(bus.send), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), NR - 1);
        chk("rst_byte", 32'(bus.bytetosend), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_done", 32'(bus.tx_done), 0);
        reset_n = 1'b1;
        run(5);
        // all four valid, unlocked: line order 0..3, then wrap back to requester 0
        base = line_log.size();
        for (int i = 0; i < NR; i++) push(i, 8'(8'h30 + i));
        drive();
        drain(3000);
        for (int i = 0; i < NR; i++) chk("rr_order", 32'(line_log[base + i]), 32'(8'h30 + i));
        n0 = acc_log.size();
        for (int i = 0; i < NR; i++) push(i, 8'(8'h40 + i));
        drive();
        drain(3000);
        chk("rr_wrap_first", acc_log[n0], 0);
        // requester 1 locked sending "abc", requester 3 waiting
        base = line_log.size();
        n0   = acc_log.size();
        force_lock = 4'b0010;
        push(1, 8'h61);
        push(1, 8'h62);
        push(1, 8'h63);
        push(3, 8'h5A);
        drive();
        n = 0;
        while (line_log.size() < base + 3 && n < 3000) begin
            step();
            n++;
        end
        run(500);
        chk("lock_grants", acc_log.size() - n0, 3);
        chk("lock_waiting", pq[3].size(), 1);
        chk("lock_idle", 32'(bus.busy), 0);
        force_lock = '0;
        push(1, 8'h64);
        drive();
        drain(3000);
        for (int i = 0; i < 5; i++) chk("lock_order", 32'(line_log[base + i]), 32'(exp5[i]));
        // single request from requester 2
        base = line_log.size();
        n0   = acc_log.size();
        push(2, 8'h41);
        drive();
        drain(2000);
        run(80);
        chk("single_grants", acc_log.size() - n0, 1);
        chk("single_owner", acc_log[n0], 2);
        chk("single_bits", 32'(last_frame), 32'({2'b11, 8'h41, 1'b0}));
        chk("single_no_second", frames, done_cnt);
        // data changes to 0xFF right after acceptance; the line must still carry 0x55
        base = line_log.size();
        push(0, 8'h55);
        drive();
        drain(2000);
        chk("hold_byte", 32'(line_log[base]), 32'h55);
        // reset during data bit 4
        push(0, 8'hA5);
        drive();
        n = 0;
        while (ubit != 4 && n < 500) begin
            step();
            n++;
        end
        chk("reach_bit4", ubit, 4);
        dsave = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_send", 32'(bus.send), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_byte", 32'(bus.bytetosend), 0);
        chk("rst_mid_owner", 32'(bus.owner), NR - 1);
        m_busy  = 1'b0;
        m_owner = NR - 1;
        m_lock  = 1'b0;
        m_byte  = 8'h00;
        line_q.delete();
        run(3);
        reset_n = 1'b1;
        run(100);
        chk("rst_no_done", done_cnt - dsave, 0);
        n0 = acc_log.size();
        push(2, 8'h22);
        push(0, 8'h11);
        drive();
        drain(3000);
        chk("rst_first", acc_log[n0], 0);
        // randomized traffic with message locks
        for (int r = 0; r < 6; r++) begin
            lock_en = NR'($urandom);
            repeat ($urandom_range(2, 5)) push($urandom_range(0, NR - 1), 8'($urandom));
            drive();
            run($urandom_range(0, 80));
            repeat ($urandom_range(2, 5)) push($urandom_range(0, NR - 1), 8'($urandom));
            drive();
            drain(20000);
        end
        run(80);
        chk("frames_vs_done", frames, done_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
